// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcodes, request kinds and word packing shared by the encoder and control decoder
package mips_pkg;
   typedef enum logic [3:0] {
      K_R    = 4'd0,
      K_ADDI = 4'd1,
      K_LW   = 4'd2,
      K_SW   = 4'd3,
      K_BEQ  = 4'd4,
      K_BNE  = 4'd5,
      K_J    = 4'd6,
      K_JAL  = 4'd7
   } kind_e;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   function automatic logic is_legal(input logic [3:0] k);
      return ~k[3];
   endfunction
   function automatic logic [5:0] opcode(input logic [3:0] k);
      case (k)
         K_ADDI:  return OP_ADDI;
         K_LW:    return OP_LW;
         K_SW:    return OP_SW;
         K_BEQ:   return OP_BEQ;
         K_BNE:   return OP_BNE;
         K_J:     return OP_J;
         K_JAL:   return OP_JAL;
         default: return OP_R;
      endcase
   endfunction
   function automatic logic [31:0] encode(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                          input logic [15:0] imm, input logic [25:0] tgt);
      return (k == K_R) ? {OP_R, rs, rt, rd, sh, fn} :
             (k == K_J || k == K_JAL) ? {opcode(k), tgt} : {opcode(k), rs, rt, imm};
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with synchronous flush; pushes when full and pops when empty are dropped
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, rp_q;
   logic [PW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;
   assign push_ok = push_i & (cnt_q != (PW+1)'(DEPTH));
   assign pop_ok  = pop_i & (cnt_q != '0);
   assign cnt_d   = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
   assign rdata_o = mem_q[rp_q];
   assign count_o = cnt_q;
   always_ff @(posedge clk) begin
      if (push_ok & ~clear_i) mem_q[wp_q] <= wdata_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clear_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_q + PW'(push_ok);
         rp_q  <= rp_q + PW'(pop_ok);
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs encode requests into MIPS words and queues them with their instruction-memory addresses
module instr_encoder
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_kind,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_shamt,
   input  logic [5:0]             in_funct,
   input  logic [15:0]            in_imm,
   input  logic [25:0]            in_target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [AW-1:0]          out_addr,
   output logic                   err,
   output logic [$clog2(DEPTH):0] count
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          live_q, err_q;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   head;
   logic          accept, push, pop;
   assign accept    = in_valid & in_ready;
   assign push      = accept & is_legal(in_kind);
   assign pop       = out_valid & out_ready;
   // live_q keeps in_ready low until the first edge after reset releases
   assign in_ready  = live_q & (count < CW'(DEPTH)) & ~clear;
   assign out_valid = count != '0;
   assign out_instr = out_valid ? head : '0;
   assign out_addr  = addr_q;
   assign err       = err_q;
   assign addr_d    = clear ? '0 : pop ? addr_q + AW'(1) : addr_q;
   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target)),
      .rdata_o (head),
      .count_o (count)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= 1'b0;
         err_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         live_q <= 1'b1;
         err_q  <= accept & ~is_legal(in_kind);
         addr_q <= addr_d;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based reference model
module tb_instr_encoder;
   localparam int DEPTH = 4;
   localparam int AW    = 10;
   logic        clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
   logic [3:0]  in_kind = 0;
   logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
   logic [5:0]  in_funct = 0;
   logic [15:0] in_imm = 0;
   logic [25:0] in_target = 0;
   logic        in_ready, out_valid, err;
   logic [31:0] out_instr;
   logic [AW-1:0] out_addr;
   logic [2:0]  count;
   int asserts = 0, fails = 0;
   int ops [8] = '{0, 8, 35, 43, 4, 5, 2, 3};

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_enc(int k, int rs, int rt, int rd, int sh, int fn, int imm, int tgt);
      longint w;
      if (k == 0) w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
      else if (k >= 6) w = longint'(ops[k]) * 67108864 + tgt;
      else w = longint'(ops[k]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
      return 32'(w);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int k, int rs, int rt, int rd, int sh, int fn, int imm, int tgt);
      in_valid = 1; in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
      in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
   endtask

   task automatic do_clear;
      in_valid = 0; clear = 1;
      tick;
      clear = 0;
      #1;
   endtask

   task automatic test_reset;
      #2;
      asserts++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
      asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      asserts++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
      asserts++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
      asserts++; if (out_addr !== '0) begin fails++; $display("FAIL rst_out_addr got %0d want 0", out_addr); end
      tick;
      rst_n = 1;
      #1;
      asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_pre_edge got %b want 0", in_ready); end
      tick;
      asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_post_edge got %b want 1", in_ready); end
   endtask

   task automatic test_addi;
      do_clear;
      out_ready = 1;
      set_req(1, 0, 8, 0, 0, 0, 5, 0);
      tick;
      in_valid = 0;
      asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", out_valid); end
      asserts++; if (out_instr !== 32'h20080005) begin fails++; $display("FAIL addi_instr got %h want 20080005", out_instr); end
      asserts++; if (out_addr !== 10'd0) begin fails++; $display("FAIL addi_addr got %0d want 0", out_addr); end
      tick;
      asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drained got %b want 0", out_valid); end
      asserts++; if (out_addr !== 10'd1) begin fails++; $display("FAIL addi_addr_inc got %0d want 1", out_addr); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp [3] = '{32'h8D090004, 32'h01095020, 32'h0C100000};
      do_clear;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) set_req(2, 8, 9, 0, 0, 0, 4, 0);
         else if (i == 1) set_req(0, 8, 9, 10, 0, 32, 0, 0);
         else set_req(7, 0, 0, 0, 0, 0, 0, 26'h0100000);
         tick;
         asserts++; if (out_instr !== exp[i]) begin fails++; $display("FAIL b2b_instr[%0d] got %h want %h", i, out_instr, exp[i]); end
         asserts++; if (out_addr !== 10'(i)) begin fails++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, out_addr, i); end
         asserts++; if (count !== 3'd1) begin fails++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
      end
      in_valid = 0;
      tick;
   endtask

   task automatic test_full;
      logic [31:0] w [5];
      for (int i = 0; i < 5; i++) w[i] = ref_enc(1, 3, 4, 0, 0, 0, (i == 4) ? 16'hBEEF : i * 17 + 1, 0);
      do_clear;
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         set_req(1, 3, 4, 0, 0, 0, i * 17 + 1, 0);
         tick;
      end
      set_req(1, 3, 4, 0, 0, 0, 16'hBEEF, 0);
      #1;
      asserts++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", count); end
      asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      tick;
      tick;
      asserts++; if (count !== 3'd4) begin fails++; $display("FAIL full_held_count got %0d want 4", count); end
      out_ready = 1;
      #1;
      asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_no_bypass got %b want 0", in_ready); end
      asserts++; if (out_instr !== w[0]) begin fails++; $display("FAIL full_head0 got %h want %h", out_instr, w[0]); end
      tick;
      asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
      asserts++; if (count !== 3'd3) begin fails++; $display("FAIL full_count_after_pop got %0d want 3", count); end
      tick;
      in_valid = 0;
      asserts++; if (count !== 3'd3) begin fails++; $display("FAIL full_push_pop_count got %0d want 3", count); end
      for (int i = 2; i < 5; i++) begin
         asserts++; if (out_instr !== w[i] || out_addr !== 10'(i)) begin fails++; $display("FAIL full_drain[%0d] got %h@%0d want %h@%0d", i, out_instr, out_addr, w[i], i); end
         tick;
      end
      asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %b want 0", out_valid); end
   endtask

   task automatic test_illegal;
      do_clear;
      out_ready = 0;
      set_req(3, 1, 2, 0, 0, 0, 16'h1234, 0);
      tick;
      set_req(15, 1, 2, 3, 4, 5, 6, 7);
      #1;
      asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ill_in_ready got %b want 1", in_ready); end
      tick;
      in_valid = 0;
      asserts++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err_pulse got %b want 1", err); end
      asserts++; if (count !== 3'd1) begin fails++; $display("FAIL ill_count got %0d want 1", count); end
      tick;
      asserts++; if (err !== 1'b0) begin fails++; $display("FAIL ill_err_once got %b want 0", err); end
      asserts++; if (out_addr !== 10'd0 || count !== 3'd1) begin fails++; $display("FAIL ill_state got addr %0d count %0d want 0/1", out_addr, count); end
      asserts++; if (out_instr !== ref_enc(3, 1, 2, 0, 0, 0, 16'h1234, 0)) begin fails++; $display("FAIL ill_head got %h", out_instr); end
   endtask

   task automatic test_wrap;
      do_clear;
      out_ready = 1;
      for (int i = 0; i <= 1024; i++) begin
         set_req(1, 1, 2, 0, 0, 0, i, 0);
         tick;
         if (i >= 1023) begin
            asserts++; if (out_addr !== 10'(i) || out_instr !== ref_enc(1, 1, 2, 0, 0, 0, i, 0)) begin fails++; $display("FAIL wrap[%0d] got %h@%0d want %h@%0d", i, out_instr, out_addr, ref_enc(1, 1, 2, 0, 0, 0, i, 0), i % 1024); end
         end
      end
      in_valid = 0;
      tick;
   endtask

   task automatic test_flush(input bit use_clear);
      do_clear;
      out_ready = 1;
      set_req(1, 0, 1, 0, 0, 0, 1, 0);
      tick;
      set_req(1, 0, 1, 0, 0, 0, 2, 0);
      tick;
      in_valid = 0;
      tick;
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         set_req(6, 0, 0, 0, 0, 0, 0, i + 100);
         tick;
      end
      in_valid = 0;
      #1;
      asserts++; if (count !== 3'd3 || out_addr !== 10'd2) begin fails++; $display("FAIL flush_setup[%0d] got count %0d addr %0d want 3/2", use_clear, count, out_addr); end
      if (use_clear) begin
         clear = 1;
         #1;
         asserts++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL clr_sync got ready %b valid %b want 0/1", in_ready, out_valid); end
         tick;
         clear = 0;
      end else begin
         rst_n = 0;
         #1;
         asserts++; if (in_ready !== 1'b0 || out_instr !== 32'h0) begin fails++; $display("FAIL rstmid_outs got ready %b instr %h want 0/0", in_ready, out_instr); end
      end
      asserts++; if (out_valid !== 1'b0 || count !== 3'd0 || out_addr !== 10'd0) begin fails++; $display("FAIL flush_empty[%0d] got valid %b count %0d addr %0d want 0/0/0", use_clear, out_valid, count, out_addr); end
      if (!use_clear) begin
         tick;
         rst_n = 1;
         tick;
      end
      set_req(0, 1, 2, 3, 4, 5, 0, 0);
      out_ready = 1;
      #1;
      asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready[%0d] got %b want 1", use_clear, in_ready); end
      tick;
      in_valid = 0;
      asserts++; if (out_instr !== ref_enc(0, 1, 2, 3, 4, 5, 0, 0) || out_addr !== 10'd0) begin fails++; $display("FAIL flush_next[%0d] got %h@%0d want %h@0", use_clear, out_instr, out_addr, ref_enc(0, 1, 2, 3, 4, 5, 0, 0)); end
      tick;
   endtask

   task automatic test_random;
      logic [31:0] q [$];
      int maddr, k;
      bit eacc, eerr;
      do_clear;
      maddr = 0;
      for (int n = 0; n < 400; n++) begin
         clear = ($urandom_range(0, 24) == 0);
         k = $urandom_range(0, 9);
         if (k >= 8) k = $urandom_range(8, 15);
         set_req(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 67108863));
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         asserts++; if (in_ready !== (q.size() < DEPTH && !clear)) begin fails++; $display("FAIL rnd_in_ready[%0d] got %b", n, in_ready); end
         asserts++; if (int'(count) !== q.size() || out_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_count[%0d] got %0d/%b want %0d", n, count, out_valid, q.size()); end
         if (q.size() != 0) begin
            asserts++; if (out_instr !== q[0] || int'(out_addr) !== maddr) begin fails++; $display("FAIL rnd_head[%0d] got %h@%0d want %h@%0d", n, out_instr, out_addr, q[0], maddr); end
         end
         eacc = in_valid && q.size() < DEPTH && !clear;
         eerr = eacc && k >= 8;
         if (clear) begin
            q.delete();
            maddr = 0;
         end else begin
            if (q.size() != 0 && out_ready) begin
               void'(q.pop_front());
               maddr = (maddr + 1) % 1024;
            end
            if (eacc && k < 8) q.push_back(ref_enc(k, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target));
         end
         tick;
         asserts++; if (err !== eerr) begin fails++; $display("FAIL rnd_err[%0d] got %b want %b", n, err, eerr); end
      end
      in_valid = 0;
      clear = 0;
   endtask

   initial begin
      test_reset;
      test_addi;
      test_back_to_back;
      test_full;
      test_illegal;
      test_wrap;
      test_flush(0);
      test_flush(1);
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
